interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/interrupt_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register map,
// CTRL/STATUS bit positions and FSM state encodings.
package interrupt_controller_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_GEN_EN_BIT = 0;

    // STATUS bit positions (vector occupies bits 2:0)
    localparam int STATUS_INSVC_BIT = 7;
    localparam int STATUS_IRQ_BIT   = 6;

    // Request FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         valid
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? 3'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: rising-edge capture into PENDING, ENABLE/CTRL
// registers, and an IDLE/REQUEST/SERVICE handshake FSM without nesting.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [1:0]         reg_addr,
    input  logic               reg_write,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    output logic               irq,
    output logic [2:0]         irq_vector,
    input  logic               irq_ack,
    input  logic               irq_done
);

    localparam logic [NUM_SRC-1:0] ZERO_MASK = {NUM_SRC{1'b0}};
    localparam logic [NUM_SRC-1:0] ONE_MASK  = NUM_SRC'(1'b1);

    logic [NUM_SRC-1:0] src_prev_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] enable_r;
    logic               gen_en_r;
    irq_state_t         state_r;
    irq_state_t         state_next_s;
    logic [2:0]         vector_r;
    logic [2:0]         vector_next_s;
    logic               irq_r;

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic [NUM_SRC-1:0] vec_mask_s;
    logic [NUM_SRC-1:0] active_s;
    logic [2:0]         prio_idx_s;
    logic               prio_valid_s;
    logic               ack_take_s;
    logic               unused_wdata_s;

    assign unused_wdata_s = ^reg_wdata;

    assign edge_s     = irq_src & ~src_prev_r;
    assign active_s   = pending_r & enable_r;
    assign vec_mask_s = ONE_MASK << vector_r;
    assign ack_clr_s  = ack_take_s ? vec_mask_s : ZERO_MASK;

    assign irq        = irq_r;
    assign irq_vector = vector_r;

    irq_prio_enc #(.N(NUM_SRC)) u_prio_enc (
        .req   (active_s),
        .idx   (prio_idx_s),
        .valid (prio_valid_s)
    );

    // Write-1-to-clear mask from a PENDING register write
    always_comb begin
        w1c_s = ZERO_MASK;
        if (reg_write && (reg_addr == ADDR_PENDING)) begin
            w1c_s = reg_wdata[NUM_SRC-1:0];
        end else begin
            w1c_s = ZERO_MASK;
        end
    end

    // Edge history and pending capture; a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_prev_r <= ZERO_MASK;
            pending_r  <= ZERO_MASK;
        end else begin
            src_prev_r <= irq_src;
            pending_r  <= (pending_r & ~(w1c_s | ack_clr_s)) | edge_s;
        end
    end

    // ENABLE and CTRL registers; unimplemented bits are simply not stored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_r <= ZERO_MASK;
            gen_en_r <= 1'b0;
        end else if (reg_write && (reg_addr == ADDR_ENABLE)) begin
            enable_r <= reg_wdata[NUM_SRC-1:0];
        end else if (reg_write && (reg_addr == ADDR_CTRL)) begin
            gen_en_r <= reg_wdata[CTRL_GEN_EN_BIT];
        end
    end

    // FSM next state: request lowest pending source, withdraw if it goes away
    always_comb begin
        state_next_s  = state_r;
        vector_next_s = vector_r;
        ack_take_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gen_en_r && prio_valid_s) begin
                    state_next_s  = ST_REQUEST;
                    vector_next_s = prio_idx_s;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (irq_ack) begin
                    ack_take_s   = 1'b1;
                    state_next_s = ST_SERVICE;
                end else if (!gen_en_r ||
                             ((pending_r & vec_mask_s) == ZERO_MASK) ||
                             ((enable_r & vec_mask_s) == ZERO_MASK)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQUEST;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SERVICE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched vector and registered irq (high exactly in REQUEST)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            vector_r <= 3'd0;
            irq_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            vector_r <= vector_next_s;
            irq_r    <= (state_next_s == ST_REQUEST);
        end
    end

    // Register read mux; unimplemented bits read as zero
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            ADDR_PENDING: reg_rdata[NUM_SRC-1:0] = pending_r;
            ADDR_ENABLE:  reg_rdata[NUM_SRC-1:0] = enable_r;
            ADDR_CTRL:    reg_rdata[CTRL_GEN_EN_BIT] = gen_en_r;
            ADDR_STATUS: begin
                reg_rdata[STATUS_INSVC_BIT] = (state_r == ST_SERVICE);
                reg_rdata[STATUS_IRQ_BIT]   = irq_r;
                reg_rdata[2:0]              = vector_r;
            end
            default: reg_rdata = 8'h00;
        endcase
    end

endmodule
